// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, select codes
// and the per-state control word.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBrEx    = 4'd8,
        StImmEx   = 4'd9,
        StImmWb   = 4'd10,
        StJEx     = 4'd11,
        StJalEx   = 4'd12,
        StJrEx    = 4'd13,
        StError   = 4'd14
    } state_t;

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;
    localparam logic [5:0] FnJr  = 6'h08;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;
    localparam logic [1:0] AluOpImm   = 2'b11;

    localparam logic [1:0] RegDstRt  = 2'b00;
    localparam logic [1:0] RegDstRd  = 2'b01;
    localparam logic [1:0] RegDstRa  = 2'b10;

    localparam logic [1:0] ToRegAlu  = 2'b00;
    localparam logic [1:0] ToRegMem  = 2'b01;
    localparam logic [1:0] ToRegPc   = 2'b10;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu  = 2'b00;
    localparam logic [1:0] PcSrcOut  = 2'b01;
    localparam logic [1:0] PcSrcJump = 2'b10;
    localparam logic [1:0] PcSrcReg  = 2'b11;

    // *_rdy enables only fire when memready is also high; branch is qualified by zero.
    typedef struct packed {
        logic       memreq;
        logic       pcwrite;
        logic       pcwrite_rdy;
        logic       branch;
        logic       irwrite_rdy;
        logic       memwrite_rdy;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic ctrl_t ctrl_word(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.memreq      = 1'b1;
                c.pcwrite_rdy = 1'b1;
                c.irwrite_rdy = 1'b1;
                c.alusrcb     = SrcBFour;
                c.pcsrc       = PcSrcAlu;
                c.aluop       = AluOpAdd;
            end
            StDecode: c.alusrcb = SrcBImmSh;
            StMemAdr: begin
                c.alusrca = 1'b1;
                c.alusrcb = SrcBImm;
            end
            StMemRd: begin
                c.memreq = 1'b1;
                c.iord   = 1'b1;
            end
            StMemWb: begin
                c.regwrite = 1'b1;
                c.regdst   = RegDstRt;
                c.memtoreg = ToRegMem;
            end
            StMemWr: begin
                c.memreq       = 1'b1;
                c.iord         = 1'b1;
                c.memwrite_rdy = 1'b1;
            end
            StRtypeEx: begin
                c.alusrca = 1'b1;
                c.alusrcb = SrcBReg;
                c.aluop   = AluOpFunct;
            end
            StRtypeWb: begin
                c.regwrite = 1'b1;
                c.regdst   = RegDstRd;
                c.memtoreg = ToRegAlu;
            end
            StBrEx: begin
                c.alusrca = 1'b1;
                c.alusrcb = SrcBReg;
                c.aluop   = AluOpSub;
                c.pcsrc   = PcSrcOut;
                c.branch  = 1'b1;
            end
            StImmEx: begin
                c.alusrca = 1'b1;
                c.alusrcb = SrcBImm;
                c.aluop   = AluOpImm;
            end
            StImmWb: begin
                c.regwrite = 1'b1;
                c.regdst   = RegDstRt;
                c.memtoreg = ToRegAlu;
            end
            StJEx: begin
                c.pcsrc   = PcSrcJump;
                c.pcwrite = 1'b1;
            end
            StJalEx: begin
                c.pcsrc    = PcSrcJump;
                c.pcwrite  = 1'b1;
                c.regwrite = 1'b1;
                c.regdst   = RegDstRa;
                c.memtoreg = ToRegPc;
            end
            StJrEx: begin
                c.pcsrc   = PcSrcReg;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic funct_is_alu(logic [5:0] f);
        return (f == FnAdd) || (f == FnSub) || (f == FnAnd) || (f == FnOr) || (f == FnSlt);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_alu_dec_ext.sv
// ALU control decoder: maps the main FSM's aluop class plus op/funct to an alucontrol code.
module alu_dec_ext
    import mips_mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = AluAdd;
        case (aluop)
            AluOpAdd: alucontrol = AluAdd;
            AluOpSub: alucontrol = AluSub;
            AluOpFunct: begin
                case (funct)
                    FnAdd:   alucontrol = AluAdd;
                    FnSub:   alucontrol = AluSub;
                    FnAnd:   alucontrol = AluAnd;
                    FnOr:    alucontrol = AluOr;
                    FnSlt:   alucontrol = AluSlt;
                    default: alucontrol = AluAdd;
                endcase
            end
            default: begin
                case (op)
                    OpAndi:  alucontrol = AluAnd;
                    OpOri:   alucontrol = AluOr;
                    OpSlti:  alucontrol = AluSlt;
                    default: alucontrol = AluAdd;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory wait states, bus timeout and a sticky error state.
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter bit          EXT_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       memreq,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       immzext,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       error,
    output logic [3:0] state
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            zext_q;
    logic            zext_dec;
    logic            timed_out;
    ctrl_t           cw;

    assign cw       = ctrl_word(state_q);
    assign zext_dec = EXT_EN && ((op == OpAndi) || (op == OpOri));

    // A ready in the same cycle the limit is reached still completes the access.
    assign timed_out = cw.memreq && (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT)) && !memready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: if (memready) state_d = StDecode;
            StDecode: begin
                state_d = StError;
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = (EXT_EN && funct == FnJr) ? StJrEx : StRtypeEx;
                    OpBeq:      state_d = StBrEx;
                    OpBne:      if (EXT_EN) state_d = StBrEx;
                    OpAddi:     state_d = StImmEx;
                    OpAndi, OpOri, OpSlti: if (EXT_EN) state_d = StImmEx;
                    OpJ:        state_d = StJEx;
                    OpJal:      if (EXT_EN) state_d = StJalEx;
                    default:    state_d = StError;
                endcase
            end
            StMemAdr:  state_d = (op == OpSw) ? StMemWr : StMemRd;
            StMemRd:   if (memready) state_d = StMemWb;
            StMemWr:   if (memready) state_d = StFetch;
            StRtypeEx: state_d = funct_is_alu(funct) ? StRtypeWb : StError;
            StImmEx:   state_d = StImmWb;
            StMemWb, StRtypeWb, StBrEx, StImmWb, StJEx, StJalEx, StJrEx: state_d = StFetch;
            StError:   state_d = StError;
            default:   state_d = StError;
        endcase
        if (timed_out) state_d = StError;
    end

    // Wait counter restarts on any state change or completed access.
    always_comb begin
        cnt_d = '0;
        if (cw.memreq && !memready && (state_d == state_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            zext_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StImmEx) zext_q <= zext_dec;
        end
    end

    alu_dec_ext u_alu_dec (
        .aluop      (cw.aluop),
        .op         (op),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Write enables and memreq are gated by reset so an aborted instruction commits nothing.
    always_comb begin
        memreq   = cw.memreq & ~reset;
        pcen     = (cw.pcwrite | (cw.pcwrite_rdy & memready)
                    | (cw.branch & (zero ^ (op == OpBne)))) & ~reset;
        irwrite  = cw.irwrite_rdy & memready & ~reset;
        memwrite = cw.memwrite_rdy & memready & ~reset;
        regwrite = cw.regwrite & ~reset;
        alusrca  = cw.alusrca;
        iord     = cw.iord;
        regdst   = cw.regdst;
        memtoreg = cw.memtoreg;
        alusrcb  = cw.alusrcb;
        pcsrc    = cw.pcsrc;
        immzext  = 1'b0;
        if (state_q == StImmEx) immzext = zext_dec;
        else if (state_q == StImmWb) immzext = zext_q;
        error    = (state_q == StError);
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: default build plus a TIMEOUT=4, EXT_EN=0 build.
module tb_mips_mc_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, memready;

    logic       memreq, pcen, memwrite, irwrite, regwrite, alusrca, iord, immzext, error;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic       x_memreq, x_pcen, x_memwrite, x_irwrite, x_regwrite, x_alusrca, x_iord;
    logic       x_immzext, x_error;
    logic [1:0] x_regdst, x_memtoreg, x_alusrcb, x_pcsrc;
    logic [2:0] x_alucontrol;
    logic [3:0] x_state;

    int n_checks = 0;
    int n_errors = 0;

    mips_mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .memreq(memreq), .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .alusrca(alusrca), .iord(iord), .immzext(immzext),
        .regdst(regdst), .memtoreg(memtoreg), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .error(error), .state(state)
    );

    mips_mc_ctrl #(.TIMEOUT(4), .EXT_EN(1'b0)) dut2 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .memreq(x_memreq), .pcen(x_pcen), .memwrite(x_memwrite), .irwrite(x_irwrite),
        .regwrite(x_regwrite), .alusrca(x_alusrca), .iord(x_iord), .immzext(x_immzext),
        .regdst(x_regdst), .memtoreg(x_memtoreg), .alusrcb(x_alusrcb), .pcsrc(x_pcsrc),
        .alucontrol(x_alucontrol), .error(x_error), .state(x_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: fetch with no wait, decode, and stop 2 time units into the execute state.
    task automatic issue(input logic [5:0] o, input logic [5:0] f);
        op = o;
        funct = f;
        memready = 1'b1;
        cyc();
        cyc();
        memready = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        op = 6'b100011;
        funct = 6'h00;
        zero = 1'b0;
        memready = 1'b0;
        #2;
        check("rst_state", state, 0);
        check("rst_memreq", memreq, 0);
        check("rst_error", error, 0);
        memready = 1'b1;
        #1;
        check("rst_gate", {irwrite, pcen, regwrite, memwrite}, 4'b0000);
        cyc();
        cyc();
        check("rst_hold", state, 0);

        // SW, then reset in the middle of MEMWR
        reset = 1'b0;
        op = 6'b101011;
        #1;
        check("fetch_ir_pc", {irwrite, pcen, alusrcb}, {1'b1, 1'b1, 2'b01});
        cyc();
        check("decode", {state, alusrcb}, {4'd1, 2'b11});
        cyc();
        check("memadr", {state, alusrca, alusrcb}, {4'd2, 1'b1, 2'b10});
        cyc();
        check("memwr", {state, memwrite, iord}, {4'd5, 1'b1, 1'b1});
        reset = 1'b1;
        #1;
        check("memwr_abort", {state, memwrite, memreq}, {4'd0, 1'b0, 1'b0});
        cyc();
        reset = 1'b0;
        memready = 1'b1;
        #1;
        check("post_rst_fetch", {irwrite, pcen}, 2'b11);

        // LW with three wait cycles in MEMRD
        op = 6'b100011;
        cyc();
        cyc();
        cyc();
        memready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) memready = 1'b1;
            #1;
            check("lw_memrd", {state, memreq, iord, regwrite}, {4'd3, 1'b1, 1'b1, 1'b0});
            cyc();
        end
        memready = 1'b0;
        #1;
        check("lw_memwb", {state, regwrite, regdst, memtoreg}, {4'd4, 1'b1, 2'b00, 2'b01});
        cyc();
        check("lw_done", {state, regwrite}, {4'd0, 1'b0});

        issue(6'b000000, 6'h22);
        check("rt_sub", {state, alucontrol, alusrca, alusrcb}, {4'd6, 3'b110, 1'b1, 2'b00});
        cyc();
        check("rt_wb", {state, regwrite, regdst, memtoreg}, {4'd7, 1'b1, 2'b01, 2'b00});
        cyc();

        issue(6'b000000, 6'h2A);
        check("rt_slt", alucontrol, 3'b111);
        cyc();
        cyc();

        issue(6'b000101, 6'h00);
        zero = 1'b0;
        #1;
        check("bne_z0", {state, pcen, pcsrc, alucontrol}, {4'd8, 1'b1, 2'b01, 3'b110});
        zero = 1'b1;
        #1;
        check("bne_z1", pcen, 0);
        cyc();

        issue(6'b000100, 6'h00);
        zero = 1'b0;
        #1;
        check("beq_z0", {state, pcen}, {4'd8, 1'b0});
        zero = 1'b1;
        #1;
        check("beq_z1", pcen, 1);
        zero = 1'b0;
        cyc();

        issue(6'b000011, 6'h00);
        check("jal", {state, regdst, memtoreg, pcsrc, pcen, regwrite},
              {4'd12, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1});
        cyc();

        issue(6'b000000, 6'h08);
        check("jr", {state, pcsrc, pcen, regwrite}, {4'd13, 2'b11, 1'b1, 1'b0});
        cyc();

        issue(6'b000010, 6'h00);
        check("j", {state, pcsrc, pcen}, {4'd11, 2'b10, 1'b1});
        cyc();

        issue(6'b001100, 6'h00);
        check("andi_ex", {state, alucontrol, immzext, alusrcb}, {4'd9, 3'b000, 1'b1, 2'b10});
        cyc();
        op = 6'b001000;
        #1;
        check("andi_wb", {state, immzext, regwrite, regdst}, {4'd10, 1'b1, 1'b1, 2'b00});
        cyc();

        issue(6'b001010, 6'h00);
        check("slti_ex", {state, alucontrol, immzext}, {4'd9, 3'b111, 1'b0});
        cyc();
        cyc();

        issue(6'b111111, 6'h00);
        check("illegal", {state, error}, {4'd14, 1'b1});
        memready = 1'b1;
        zero = 1'b1;
        #1;
        check("err_quiet", {memreq, pcen, irwrite, regwrite, memwrite}, 5'b00000);
        cyc();
        cyc();
        check("err_sticky", {state, error, pcen}, {4'd14, 1'b1, 1'b0});
        zero = 1'b0;

        // EXT_EN=0 build rejects ORI
        apply_reset();
        check("x_rst", {x_state, x_error}, {4'd0, 1'b0});
        issue(6'b001101, 6'h00);
        check("x_ori_err", {x_state, x_error}, {4'd14, 1'b1});
        memready = 1'b1;
        #1;
        check("x_err_quiet", {x_memreq, x_pcen, x_irwrite, x_regwrite, x_memwrite}, 5'b00000);

        // TIMEOUT=4: five waiting FETCH cycles, then ERROR
        apply_reset();
        memready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("x_to_wait", {x_state, x_memreq}, {4'd0, 1'b1});
            cyc();
        end
        check("x_to_err", {x_state, x_error}, {4'd14, 1'b1});

        // Ready arriving on the limit cycle completes the fetch
        apply_reset();
        memready = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        memready = 1'b1;
        #1;
        check("x_to_last", {x_state, x_irwrite}, {4'd0, 1'b1});
        cyc();
        check("x_to_ok", {x_state, x_error}, {4'd1, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Parametrised multicycle MIPS control unit, the successor to the current `controller`/`maindec`/`aludec` trio. It drives the same multicycle datapath and adds several capabilities:
- a memory ready handshake with wait states and a bus timeout;
- a sticky error state for illegal opcodes;
- the ANDI/ORI/SLTI/BNE/JAL/JR instructions, selectable by parameter.

It sits between the instruction register fields and the datapath mux/enable inputs inside `mips`.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum consecutive cycles in a memory state with `memready`=0 before entering ERROR; 0 disables the timeout.
- `EXT_EN`, default 1: 1 enables ANDI/ORI/SLTI/BNE/JAL/JR; 0 makes them illegal (ERROR).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 6: instr[31:26].
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag.
- `memready` in 1: memory completes the access this cycle.
- `memreq` out 1: memory access request.
- `pcen`, `memwrite`, `irwrite`, `regwrite`, `alusrca`, `iord` out 1 each: datapath enables and selects.
- `immzext` out 1: zero-extend the immediate (ANDI/ORI).
- `regdst` out 2: 00 rt, 01 rd, 10 register 31.
- `memtoreg` out 2: 00 aluout, 01 data, 10 pc.
- `alusrcb` out 2: 00 B, 01 constant 4, 10 signimm, 11 signimm<<2.
- `pcsrc` out 2: 00 aluresult, 01 aluout, 10 jump target, 11 A register (JR).
- `alucontrol` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `error` out 1: sticky fault flag.
- `state` out 4: current state, exposed for debug and verification.

## Operation
States and encoding:
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7.
- BREX 8, IMMEX 9, IMMWB 10, JEX 11, JALEX 12, JREX 13, ERROR 14.

State behaviour and transitions:
- FETCH: `memreq`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `pcsrc`=00, add. `irwrite` and `pcen` equal `memready`. Move to DECODE on `memready`, otherwise stay.
- DECODE: `alusrcb`=11, add.
  - LW/SW go to MEMADR; R-type goes to RTYPEEX, or to JREX when funct=001000 and `EXT_EN`.
  - BEQ, or BNE with `EXT_EN`, goes to BREX.
  - ADDI, or ANDI/ORI/SLTI with `EXT_EN`, goes to IMMEX.
  - J goes to JEX; JAL with `EXT_EN` goes to JALEX.
  - Anything else goes to ERROR.
- MEMADR: `alusrca`=1, `alusrcb`=10, add. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: `memreq`=1, `iord`=1. Move to MEMWB on `memready`.
- MEMWB: `regwrite`=1, `regdst`=00, `memtoreg`=01. Next state FETCH.
- MEMWR: `memreq`=1, `iord`=1, `memwrite`=`memready`. Move to FETCH on `memready`.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, alucontrol decoded from funct. Unknown funct goes to ERROR.
- RTYPEWB: `regwrite`=1, `regdst`=01, `memtoreg`=00. Next state FETCH.
- BREX: `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01, `pcen`=`zero` XOR (op==BNE). Next state FETCH.
- IMMEX: `alusrca`=1, `alusrcb`=10.
  - ALU op: ADDI add, ANDI and, ORI or, SLTI slt.
  - `immzext`=1 for ANDI and ORI.
- IMMWB: `regwrite`=1, `regdst`=00, `memtoreg`=00. `immzext` is held at its IMMEX value.
- JEX: `pcsrc`=10, `pcen`=1.
- JALEX: `pcsrc`=10, `pcen`=1, `regwrite`=1, `regdst`=10, `memtoreg`=10. The register file captures the already-incremented PC, i.e. PC+4.
- JREX: `pcsrc`=11, `pcen`=1.
- ERROR: all enables and `memreq` are 0, `error`=1. Left only by `reset`.

Opcode and funct values:
- LW 100011, SW 101011, RTYPE 000000, BEQ 000100, BNE 000101.
- ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, J 000010, JAL 000011.
- funct: 20 add, 22 sub, 24 and, 25 or, 2A slt, 08 jr.

Timeout:
- A counter runs only in FETCH, MEMRD and MEMWR.
- It clears on every state change and on `memready`, and increments each waiting cycle.
- When the count equals `TIMEOUT` (with `TIMEOUT`≠0) and `memready`=0, the next state is ERROR.
- Counter width is clog2(`TIMEOUT`+1), minimum 1.

## Timing
- Outputs are Moore decodes of `state`, except these Mealy terms: `pcen` (`zero`, `memready`), `irwrite`, `memwrite` (`memready`), and the DECODE/IMMEX decode of `op`/`funct`.
- Zero-wait instruction latencies: LW 5 cycles; SW, R-type, ADDI-class 4; branch and jumps 3. Each memory wait adds 1 cycle.
- Reset behaviour:
  - `state`=FETCH, counter=0, `error`=0.
  - While `reset` is high, `memreq`, `pcen`, `irwrite`, `regwrite` and `memwrite` are forced to 0.
  - An asserted `reset` mid-instruction aborts the instruction; no write enable reaches the next edge.
- `memready` is sampled only while `memreq`=1 and is ignored elsewhere.
- A `memready` in the same cycle the counter hits `TIMEOUT` completes the access; there is no error.

## Structure
- Shared package `mips_mc_pkg`:
  - the state encoding;
  - opcode and funct constants;
  - alucontrol codes;
  - `regdst`, `memtoreg`, `alusrcb` and `pcsrc` select codes.
- The existing `maindec` 15-bit control-word approach is extended to a wider word.
- One sub-module, `alu_dec_ext`: combinational; inputs aluop[1:0], `op`, `funct`; output `alucontrol`. aluop codes: 00 add, 01 sub, 10 funct, 11 immediate-class.

## Test plan
- Reset asserted mid-MEMWR → `memwrite` drops to 0 immediately and `state` reads 0. Release reset with `memready`=1 → FETCH asserts `irwrite`=1 and `pcen`=1.
- LW, `memready` low for 3 cycles in MEMRD → `memreq`=1 held for 4 cycles, `regwrite`=1 exactly one cycle later in MEMWB, total 8 cycles.
- BNE with `zero`=0 → `pcen`=1 in BREX. BNE with `zero`=1 → `pcen`=0. BEQ gives the opposite in both cases.
- JAL → JALEX with `regdst`=10, `memtoreg`=10, `pcsrc`=10, `pcen`=1 and `regwrite`=1, all in one cycle. JR (funct 08) → JREX with `pcsrc`=11.
- `EXT_EN`=0 with ORI, or `op`=111111 → ERROR at DECODE+1, `error`=1, all enables 0 until reset.
- `TIMEOUT`=4 with `memready` held low in FETCH → ERROR after exactly 5 FETCH cycles. `memready` high on the 5th cycle → DECODE, no error.
